output_deserializer: RTL and testbench

- Inverse of the layer input serializer: collects a serial stream of `dataWidth`-bit words, one per accepted cycle, into a packed parallel vector of `numValues` slots.
- Sits after a serial-output layer (or between layers) and feeds the next parallel-input layer or a classifier.
- Uses a valid/ready handshake on the output, with backpressure on the serial side while a full frame is held.

---
 rtl/nn_deser_pkg.sv | 13 +
 rtl/argmax_tracker.sv | 47 ++++
 rtl/output_deserializer.sv | 130 +++++++++++++
 tb/tb_output_deserializer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/nn_deser_pkg.sv
// Shared types and default Q-format constants for the serial-to-parallel output deserializer.
package nn_deser_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } deser_state_e;

  localparam int DATA_INT_WIDTH  = 6;
  localparam int DATA_FRAC_WIDTH = 10;

endpackage

// File: rtl/argmax_tracker.sv
// Running signed maximum over the words of one frame; ties keep the lowest slot index.
module argmax_tracker #(
  parameter int dataWidth  = 16,
  parameter int indexWidth = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  wrEn,
  input  logic [indexWidth-1:0] wrIdx,
  input  logic [dataWidth-1:0]  wrData,
  output logic [indexWidth-1:0] argmaxIdx
);

  logic [dataWidth-1:0]  max_q, max_d;
  logic [indexWidth-1:0] idx_q, idx_d;

  // Slot 0 seeds the max; later words win only when strictly greater.
  always_comb begin
    max_d = max_q;
    idx_d = idx_q;
    if (start) begin
      max_d = wrData;
      idx_d = {indexWidth{1'b0}};
    end else if (wrEn && ($signed(wrData) > $signed(max_q))) begin
      max_d = wrData;
      idx_d = wrIdx;
    end else begin
      max_d = max_q;
      idx_d = idx_q;
    end
  end

  // Running max and index registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_q <= {dataWidth{1'b0}};
      idx_q <= {indexWidth{1'b0}};
    end else begin
      max_q <= max_d;
      idx_q <= idx_d;
    end
  end

  assign argmaxIdx = idx_q;

endmodule

// File: rtl/output_deserializer.sv
// Collects a serial word stream into a packed frame with valid/ready output handshake.
// Optional argmax tracking is enabled by defining OUT_ARGMAX_EN.
module output_deserializer
  import nn_deser_pkg::*;
#(
  parameter int numValues    = 10,
  parameter int dataWidth    = DATA_INT_WIDTH + DATA_FRAC_WIDTH,
  parameter int counterWidth = $clog2(numValues + 1),
  parameter int indexWidth   = (numValues > 1) ? $clog2(numValues) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [dataWidth-1:0]           serialIn,
  input  logic                           serialValid,
  output logic                           serialReady,
  output logic [dataWidth*numValues-1:0] deserOut,
  output logic                           deserOutValid,
  input  logic                           outReady,
`ifdef OUT_ARGMAX_EN
  output logic [indexWidth-1:0]          argmaxIdx,
`endif
  output logic                           overflowErr
);

  deser_state_e                   state_q, state_d;
  logic [counterWidth-1:0]        count_q, count_d;
  logic [dataWidth*numValues-1:0] data_q, data_d;
  logic                           valid_q;
  logic                           ovf_q, ovf_d;
  logic                           wr_en_s;
  logic [indexWidth-1:0]          wr_idx_s;

  // Slot index is below numValues whenever a write can happen, so indexWidth bits suffice.
  assign wr_idx_s = count_q[indexWidth-1:0];

  // Next-state, slot-write and overflow logic.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    wr_en_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (serialValid) begin
          wr_en_s = 1'b1;
          count_d = counterWidth'(1);
          state_d = (numValues == 1) ? HOLD : COLLECT;
        end else begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        if (serialValid) begin
          wr_en_s = 1'b1;
          count_d = count_q + counterWidth'(1);
          if (count_q == counterWidth'(numValues - 1)) begin
            state_d = HOLD;
          end else begin
            state_d = COLLECT;
          end
        end else begin
          state_d = COLLECT;
        end
      end
      HOLD: begin
        ovf_d = ovf_q | serialValid;
        if (outReady) begin
          state_d = IDLE;
          count_d = {counterWidth{1'b0}};
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = {counterWidth{1'b0}};
      end
    endcase
  end

  // Per-slot write mux; unwritten slots retain the previous frame.
  always_comb begin
    data_d = data_q;
    for (int k = 0; k < numValues; k++) begin
      data_d[k*dataWidth +: dataWidth] = (wr_en_s && (wr_idx_s == indexWidth'(k)))
                                         ? serialIn : data_q[k*dataWidth +: dataWidth];
    end
  end

  // State, frame and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= {counterWidth{1'b0}};
      data_q  <= {(dataWidth*numValues){1'b0}};
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
      valid_q <= (state_d == HOLD);
      ovf_q   <= ovf_d;
    end
  end

  assign serialReady   = (state_q != HOLD);
  assign deserOut      = data_q;
  assign deserOutValid = valid_q;
  assign overflowErr   = ovf_q;

`ifdef OUT_ARGMAX_EN
  logic start_s;
  assign start_s = wr_en_s && (state_q == IDLE);

  argmax_tracker #(
    .dataWidth (dataWidth),
    .indexWidth(indexWidth)
  ) u_argmax (
    .clk      (clk),
    .reset    (reset),
    .start    (start_s),
    .wrEn     (wr_en_s),
    .wrIdx    (wr_idx_s),
    .wrData   (serialIn),
    .argmaxIdx(argmaxIdx)
  );
`endif

endmodule

// File: tb/tb_output_deserializer.sv
// Self-checking bench: frame-level model compared every cycle plus directed literal checks.
module tb_output_deserializer;

  localparam int N = 10;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   serialIn;
  logic           serialValid;
  logic           outReady;
  logic           serialReady;
  logic [N*W-1:0] deserOut;
  logic           deserOutValid;
  logic           overflowErr;

  logic [W-1:0]   in1;
  logic           v1, r1, ready1, valid1, ovf1;
  logic [W-1:0]   out1;

`ifdef OUT_ARGMAX_EN
  logic [3:0]     argmaxIdx;
  logic [0:0]     argmaxIdx1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  output_deserializer #(.numValues(N), .dataWidth(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .serialIn     (serialIn),
    .serialValid  (serialValid),
    .serialReady  (serialReady),
    .deserOut     (deserOut),
    .deserOutValid(deserOutValid),
    .outReady     (outReady),
`ifdef OUT_ARGMAX_EN
    .argmaxIdx    (argmaxIdx),
`endif
    .overflowErr  (overflowErr)
  );

  output_deserializer #(.numValues(1), .dataWidth(W)) dut1 (
    .clk          (clk),
    .reset        (reset),
    .serialIn     (in1),
    .serialValid  (v1),
    .serialReady  (ready1),
    .deserOut     (out1),
    .deserOutValid(valid1),
    .outReady     (r1),
`ifdef OUT_ARGMAX_EN
    .argmaxIdx    (argmaxIdx1),
`endif
    .overflowErr  (ovf1)
  );

  // Frame model: m_n words collected so far; m_n == N means a complete frame is held.
  logic [W-1:0] m_slot [N];
  int           m_n;
  bit           m_ovf;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_n   <= 0;
      m_ovf <= 1'b0;
      for (int k = 0; k < N; k++) m_slot[k] <= '0;
    end else if (m_n < N) begin
      if (serialValid) begin
        m_slot[m_n] <= serialIn;
        m_n         <= m_n + 1;
      end
    end else begin
      if (serialValid) m_ovf <= 1'b1;
      if (outReady) m_n <= 0;
    end
  end

  function automatic logic [N*W-1:0] model_frame();
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = m_slot[k];
    return v;
  endfunction

  function automatic int model_argmax();
    int best = 0;
    for (int k = 1; k < N; k++)
      if ($signed(m_slot[k]) > $signed(m_slot[best])) best = k;
    return best;
  endfunction

  task automatic check(input string nm, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    check("valid", {159'd0, deserOutValid}, {159'd0, m_n == N});
    check("ready", {159'd0, serialReady}, {159'd0, m_n < N});
    check("ovf", {159'd0, overflowErr}, {159'd0, m_ovf});
    check("frame", deserOut, model_frame());
`ifdef OUT_ARGMAX_EN
    if (m_n == N) check("argmax", {156'd0, argmaxIdx}, (N*W)'(model_argmax()));
`endif
  end

  task automatic send(input logic [W-1:0] d, input logic v, input logic rdy);
    serialIn    = d;
    serialValid = v;
    outReady    = rdy;
    @(posedge clk);
    #1;
    serialValid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; serialIn = '0; serialValid = 1'b0; outReady = 1'b0;
    in1 = '0; v1 = 1'b0; r1 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset mid-frame
    for (int k = 0; k < 4; k++) send(W'(16'h00F0 + k), 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    check("rst_valid", {159'd0, deserOutValid}, 160'd0);
    check("rst_ovf", {159'd0, overflowErr}, 160'd0);
    check("rst_ready", {159'd0, serialReady}, 160'd1);
    check("rst_frame", deserOut, 160'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < N; k++) send(W'(16'h0100 + k), 1'b1, 1'b0);
    check("t1_valid", {159'd0, deserOutValid}, 160'd1);
    check("t1_slot0", {144'd0, deserOut[W-1:0]}, 160'h0100);
    check("t1_slot9", {144'd0, deserOut[9*W +: W]}, 160'h0109);
    send('0, 1'b0, 1'b1);

    // Back-to-back frame with outReady held high
    for (int k = 0; k < N - 1; k++) send(W'(k + 1), 1'b1, 1'b1);
    check("t2_pre", {159'd0, deserOutValid}, 160'd0);
    send(16'h000A, 1'b1, 1'b1);
    check("t2_valid", {159'd0, deserOutValid}, 160'd1);
    check("t2_frame", deserOut, 160'h000A_0009_0008_0007_0006_0005_0004_0003_0002_0001);
    send('0, 1'b0, 1'b1);
    check("t2_drop", {159'd0, deserOutValid}, 160'd0);

    // Gapped input, then backpressure for 5 cycles
    for (int k = 0; k < N; k++) begin
      send(W'(16'h0200 + k), 1'b1, 1'b0);
      send(16'hDEAD, 1'b0, 1'b0);
    end
    for (int k = 0; k < 4; k++) send('0, 1'b0, 1'b0);
    check("t3_valid", {159'd0, deserOutValid}, 160'd1);
    check("t3_ready", {159'd0, serialReady}, 160'd0);

    // Overflow in HOLD
    send(16'h7FFF, 1'b1, 1'b0);
    check("t4_ovf", {159'd0, overflowErr}, 160'd1);
    check("t4_slot0", {144'd0, deserOut[W-1:0]}, 160'h0200);
    check("t4_slot9", {144'd0, deserOut[9*W +: W]}, 160'h0209);
    send('0, 1'b0, 1'b1);
    send('0, 1'b0, 1'b0);
    check("t4_sticky", {159'd0, overflowErr}, 160'd1);
    check("t4_idle", {159'd0, deserOutValid}, 160'd0);

    // Argmax frames: {-3,5,2,5,-1,0,0,0,0,0} then all -1.0
    send(16'hF400, 1'b1, 1'b0);
    send(16'h1400, 1'b1, 1'b0);
    send(16'h0800, 1'b1, 1'b0);
    send(16'h1400, 1'b1, 1'b0);
    send(16'hFC00, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) send(16'h0000, 1'b1, 1'b0);
    check("t5_valid", {159'd0, deserOutValid}, 160'd1);
`ifdef OUT_ARGMAX_EN
    check("t5_tie", {156'd0, argmaxIdx}, 160'd1);
`endif
    send('0, 1'b0, 1'b1);
    for (int k = 0; k < N; k++) send(16'hFC00, 1'b1, 1'b0);
    check("t5_neg_frame", deserOut, {N{16'hFC00}});
`ifdef OUT_ARGMAX_EN
    check("t5_neg", {156'd0, argmaxIdx}, 160'd0);
`endif
    send('0, 1'b0, 1'b1);

    // Single-slot build
    in1 = 16'h1234; v1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0;
    check("t6_valid", {159'd0, valid1}, 160'd1);
    check("t6_frame", {144'd0, out1}, 160'h1234);
    check("t6_ready", {159'd0, ready1}, 160'd0);
    r1 = 1'b1;
    @(posedge clk); #1;
    r1 = 1'b0;
    check("t6_drop", {159'd0, valid1}, 160'd0);
    check("t6_ready2", {159'd0, ready1}, 160'd1);
    check("t6_ovf", {159'd0, ovf1}, 160'd0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
